// File: rtl/contador_nb_bloqueio.sv
// Failed-attempt counter with timed lockout for the DigiLock keypad path.
// Ports: clk, reset (async, active-low), add/clr events in; count, s, locked, lock_rem, unlock_p out.
module contador_nb_bloqueio #(
  parameter int WIDTH       = 4,
  parameter int MAX         = 3,
  parameter int LOCK_CYCLES = 8,
  parameter int LOCK_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              add,
  input  logic              clr,
  output logic [WIDTH-1:0]  count,
  output logic              s,
  output logic              locked,
  output logic [LOCK_W-1:0] lock_rem,
  output logic              unlock_p
);

  localparam logic [WIDTH-1:0]  MAX_C = WIDTH'(MAX);
  localparam logic [WIDTH-1:0]  ONE_C = WIDTH'(1);
  localparam logic [LOCK_W-1:0] LC_C  = LOCK_W'(LOCK_CYCLES);
  localparam logic [LOCK_W-1:0] LONE  = LOCK_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    COUNTING,
    LOCKED
  } state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    count_q;
  logic                s_q;
  logic                locked_q;
  logic [LOCK_W-1:0]   rem_q;
  logic                unlock_q;
  logic [WIDTH-1:0]    inc;

  // count_q < MAX outside LOCKED, so inc never wraps
  assign inc = count_q + ONE_C;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      s_q      <= 1'b0;
      locked_q <= 1'b0;
      rem_q    <= '0;
      unlock_q <= 1'b0;
    end else begin
      unlock_q <= 1'b0;
      unique case (state_q)
        IDLE, COUNTING: begin
          if (clr) begin
            count_q <= '0;
            state_q <= IDLE;
          end else if (add) begin
            if (inc == MAX_C) begin
              count_q  <= MAX_C;
              s_q      <= 1'b1;
              locked_q <= 1'b1;
              rem_q    <= LC_C;
              state_q  <= LOCKED;
            end else begin
              count_q <= inc;
              state_q <= COUNTING;
            end
          end
        end
        LOCKED: begin
          // inputs are ignored for the whole window
          if (rem_q == LONE) begin
            count_q  <= '0;
            s_q      <= 1'b0;
            locked_q <= 1'b0;
            rem_q    <= '0;
            unlock_q <= 1'b1;
            state_q  <= IDLE;
          end else begin
            rem_q <= rem_q - LONE;
          end
        end
        default: begin
          count_q  <= '0;
          s_q      <= 1'b0;
          locked_q <= 1'b0;
          rem_q    <= '0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign count    = count_q;
  assign s        = s_q;
  assign locked   = locked_q;
  assign lock_rem = rem_q;
  assign unlock_p = unlock_q;

endmodule

// File: tb/tb_contador_nb_bloqueio.sv
// Bench for contador_nb_bloqueio: default instance plus MAX=1/LOCK_CYCLES=1 instance.
// Both are compared each cycle against a counting model.
module tb_contador_nb_bloqueio;
  localparam int W  = 4;
  localparam int LW = 8;
  localparam int VW = W + LW + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic add_a = 1'b0, clr_a = 1'b0;
  logic add_b = 1'b0, clr_b = 1'b0;
  logic [W-1:0]  count_a, count_b;
  logic          s_a, s_b, locked_a, locked_b;
  logic          unl_a, unl_b;
  logic [LW-1:0] rem_a, rem_b;

  contador_nb_bloqueio #(
    .WIDTH(W), .MAX(3), .LOCK_CYCLES(8), .LOCK_W(LW)
  ) dut_a (
    .clk(clk), .reset(rst_n), .add(add_a), .clr(clr_a),
    .count(count_a), .s(s_a), .locked(locked_a),
    .lock_rem(rem_a), .unlock_p(unl_a)
  );

  contador_nb_bloqueio #(
    .WIDTH(W), .MAX(1), .LOCK_CYCLES(1), .LOCK_W(LW)
  ) dut_b (
    .clk(clk), .reset(rst_n), .add(add_b), .clr(clr_b),
    .count(count_b), .s(s_b), .locked(locked_b),
    .lock_rem(rem_b), .unlock_p(unl_b)
  );

  int errors = 0;
  int checks = 0;

  int ca = 0, ra = 0; bit ua = 0;
  int cb = 0, rb = 0; bit ub = 0;

  logic [VW-1:0] obs_a, obs_b;
  assign obs_a = {count_a, s_a, locked_a, rem_a, unl_a};
  assign obs_b = {count_b, s_b, locked_b, rem_b, unl_b};

  // model: rem>0 means a lockout window is running
  task automatic mstep(input int mx, input int lc,
                       input logic a, input logic c,
                       inout int cnt, inout int rem, inout bit unl);
    unl = 0;
    if (rem > 0) begin
      rem = rem - 1;
      if (rem == 0) begin
        cnt = 0;
        unl = 1;
      end
    end else if (c) begin
      cnt = 0;
    end else if (a) begin
      cnt = cnt + 1;
      if (cnt == mx) rem = lc;
    end
  endtask

  function automatic logic [VW-1:0] expv(input int cnt, input int rem,
                                         input bit unl, input int mx);
    return {W'(cnt), cnt == mx, rem > 0, LW'(rem), unl};
  endfunction

  task automatic mreset();
    ca = 0; ra = 0; ua = 0;
    cb = 0; rb = 0; ub = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) begin
      mstep(3, 8, add_a, clr_a, ca, ra, ua);
      mstep(1, 1, add_b, clr_b, cb, rb, ub);
    end
    #1;
  endtask

  task automatic test_reset();
    #2;
    for (int i = 0; i < 4; i++) begin
      add_a = ~add_a;
      add_b = ~add_b;
      #1;
      checks++;
      if (obs_a !== '0) begin
        errors++;
        $display("FAIL reset_a t=%0t got=%h exp=0", $time, obs_a);
      end
      checks++;
      if (obs_b !== '0) begin
        errors++;
        $display("FAIL reset_b t=%0t got=%h exp=0", $time, obs_b);
      end
      #4;
    end
    add_a = 1'b0;
    add_b = 1'b0;
    mreset();
    rst_n = 1'b1;
  endtask

  task automatic test_count_clear();
    logic [1:0] seq_add [4];
    logic [1:0] seq_clr [4];
    seq_add = '{1, 1, 0, 1};
    seq_clr = '{0, 0, 1, 1};
    for (int i = 0; i < 4; i++) begin
      add_a = seq_add[i][0];
      clr_a = seq_clr[i][0];
      cycle();
      checks++;
      if (obs_a !== expv(ca, ra, ua, 3)) begin
        errors++;
        $display("FAIL count_clear step=%0d got=%h exp=%h",
                 i, obs_a, expv(ca, ra, ua, 3));
      end
    end
    checks++;
    if (count_a !== 4'd0) begin
      errors++;
      $display("FAIL add_clr_same count=%0d exp=0", count_a);
    end
    add_a = 1'b0;
    clr_a = 1'b0;
  endtask

  task automatic test_lockout();
    add_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (obs_a !== expv(ca, ra, ua, 3)) begin
        errors++;
        $display("FAIL lock_entry step=%0d got=%h exp=%h",
                 i, obs_a, expv(ca, ra, ua, 3));
      end
    end
    checks++;
    if (rem_a !== 8'd8 || count_a !== 4'd3 || !s_a || !locked_a) begin
      errors++;
      $display("FAIL lock_entry_vals rem=%0d cnt=%0d exp rem=8 cnt=3",
               rem_a, count_a);
    end
    clr_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      checks++;
      if (obs_a !== expv(ca, ra, ua, 3)) begin
        errors++;
        $display("FAIL lock_window step=%0d got=%h exp=%h",
                 i, obs_a, expv(ca, ra, ua, 3));
      end
    end
    checks++;
    if (unl_a !== 1'b1 || locked_a !== 1'b0 || count_a !== 4'd0) begin
      errors++;
      $display("FAIL lock_exit unl=%b locked=%b cnt=%0d exp 1 0 0",
               unl_a, locked_a, count_a);
    end
    clr_a = 1'b0;
    cycle();
    checks++;
    if (obs_a !== expv(ca, ra, ua, 3) || count_a !== 4'd1) begin
      errors++;
      $display("FAIL rearm got=%h exp=%h", obs_a, expv(ca, ra, ua, 3));
    end
    add_a = 1'b0;
    clr_a = 1'b1;
    cycle();
    clr_a = 1'b0;
  endtask

  task automatic test_async_abort();
    add_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) add_a = 1'b0;
      cycle();
    end
    checks++;
    if (obs_a !== expv(ca, ra, ua, 3) || rem_a !== 8'd5) begin
      errors++;
      $display("FAIL abort_pre got=%h exp=%h", obs_a, expv(ca, ra, ua, 3));
    end
    #3;
    rst_n = 1'b0;
    mreset();
    #1;
    checks++;
    if (obs_a !== '0) begin
      errors++;
      $display("FAIL abort_async got=%h exp=0", obs_a);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (obs_a !== '0) begin
        errors++;
        $display("FAIL abort_hold step=%0d got=%h exp=0", i, obs_a);
      end
    end
    #3;
    rst_n = 1'b1;
    cycle();
    checks++;
    if (obs_a !== expv(ca, ra, ua, 3)) begin
      errors++;
      $display("FAIL abort_after got=%h exp=%h", obs_a, expv(ca, ra, ua, 3));
    end
  endtask

  task automatic test_generic();
    add_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) add_b = 1'b0;
      if (i == 3) add_b = 1'b1;
      cycle();
      checks++;
      if (obs_b !== expv(cb, rb, ub, 1)) begin
        errors++;
        $display("FAIL generic step=%0d got=%h exp=%h",
                 i, obs_b, expv(cb, rb, ub, 1));
      end
    end
    add_b = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      add_a = ($urandom_range(0, 3) != 0);
      clr_a = ($urandom_range(0, 9) == 0);
      add_b = ($urandom_range(0, 1) != 0);
      clr_b = ($urandom_range(0, 5) == 0);
      cycle();
      checks++;
      if (obs_a !== expv(ca, ra, ua, 3)) begin
        errors++;
        $display("FAIL random_a cyc=%0d got=%h exp=%h",
                 i, obs_a, expv(ca, ra, ua, 3));
      end
      checks++;
      if (obs_b !== expv(cb, rb, ub, 1)) begin
        errors++;
        $display("FAIL random_b cyc=%0d got=%h exp=%h",
                 i, obs_b, expv(cb, rb, ub, 1));
      end
    end
    add_a = 1'b0; clr_a = 1'b0;
    add_b = 1'b0; clr_b = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_count_clear();
    test_lockout();
    test_async_abort();
    test_generic();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
